// File: rtl/decode_pkg.sv
// Shared decode definitions: ISA field positions, op encoding and the decoded-field record.
package decode_pkg;

  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned FIELD_W  = 5;
  localparam int unsigned FUNC_HI  = 31;
  localparam int unsigned FUNC_LO  = 27;
  localparam int unsigned RS_HI    = 26;
  localparam int unsigned RS_LO    = 22;
  localparam int unsigned RD_HI    = 21;
  localparam int unsigned RD_LO    = 17;
  localparam int unsigned RT_HI    = 16;
  localparam int unsigned RT_LO    = 12;
  localparam int unsigned SA_HI    = 11;
  localparam int unsigned SA_LO    = 7;
  localparam int unsigned IMM_HI   = 16;
  localparam int unsigned IMM_LO   = 3;
  localparam int unsigned IMM_W    = IMM_HI - IMM_LO + 1;
  localparam int unsigned JIMM_HI  = 25;
  localparam int unsigned JIMM_LO  = 3;
  localparam int unsigned JIMM_W   = JIMM_HI - JIMM_LO + 1;
  localparam int unsigned OP_HI    = 2;
  localparam int unsigned OP_LO    = 1;
  localparam int unsigned STOP_BIT = 0;

  typedef enum logic [1:0] {
    OP_R = 2'b00,
    OP_J = 2'b01,
    OP_I = 2'b10,
    OP_S = 2'b11
  } op_e;

  typedef struct packed {
    op_e                op;
    logic [FIELD_W-1:0] func;
    logic [FIELD_W-1:0] rs;
    logic [FIELD_W-1:0] rd;
    logic [FIELD_W-1:0] rt;
    logic [FIELD_W-1:0] sa;
    logic               stop;
  } dec_fields_t;

endpackage

// File: rtl/decode_stage_hs_fields.sv
// Combinational field split, immediate extension and branch/jump target generation.
module decode_fields
  import decode_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned IMM_SIGNED  = 1,
  parameter int unsigned TARGET_MODE = 1
) (
  input  logic [INSTR_W-1:0] instr,
  input  logic [XLEN-1:0]    pc,
  output dec_fields_t        fields,
  output logic [XLEN-1:0]    imm,
  output logic [XLEN-1:0]    pcb,
  output logic [XLEN-1:0]    pcj
);

  logic [IMM_W-1:0]  imm_raw;
  logic [JIMM_W-1:0] jimm_raw;
  logic [XLEN-1:0]   jimm;

  assign fields.op   = op_e'(instr[OP_HI:OP_LO]);
  assign fields.func = instr[FUNC_HI:FUNC_LO];
  assign fields.rs   = instr[RS_HI:RS_LO];
  assign fields.rd   = instr[RD_HI:RD_LO];
  assign fields.rt   = instr[RT_HI:RT_LO];
  assign fields.sa   = instr[SA_HI:SA_LO];
  assign fields.stop = instr[STOP_BIT];

  assign imm_raw  = instr[IMM_HI:IMM_LO];
  assign jimm_raw = instr[JIMM_HI:JIMM_LO];

  // Fill bits are either the immediate's top bit or zero.
  assign imm  = (IMM_SIGNED != 0) ? {{(XLEN-IMM_W){imm_raw[IMM_W-1]}}, imm_raw}
                                  : {{(XLEN-IMM_W){1'b0}}, imm_raw};
  assign jimm = (IMM_SIGNED != 0) ? {{(XLEN-JIMM_W){jimm_raw[JIMM_W-1]}}, jimm_raw}
                                  : {{(XLEN-JIMM_W){1'b0}}, jimm_raw};

  // PC-relative targets wrap silently modulo 2^XLEN.
  assign pcb = (TARGET_MODE != 0) ? XLEN'(pc + imm)  : imm;
  assign pcj = (TARGET_MODE != 0) ? XLEN'(pc + jimm) : jimm;

endmodule

// File: rtl/decode_stage_hs.sv
// Valid/ready decode stage: decoded entries held in a main register plus one skid entry.
module decode_stage_hs
  import decode_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned IMM_SIGNED  = 1,
  parameter int unsigned TARGET_MODE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [XLEN-1:0]    in_pc,
  input  logic               flush,
  input  logic               resume,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [1:0]         out_op,
  output logic [4:0]         out_func,
  output logic [4:0]         out_rs,
  output logic [4:0]         out_rd,
  output logic [4:0]         out_rt,
  output logic [4:0]         out_sa,
  output logic               out_stop,
  output logic [XLEN-1:0]    out_imm,
  output logic [XLEN-1:0]    out_pc,
  output logic [XLEN-1:0]    out_pcb,
  output logic [XLEN-1:0]    out_pcj,
  output logic               halted
);

  typedef struct packed {
    dec_fields_t     f;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcb;
    logic [XLEN-1:0] pcj;
  } entry_t;

  entry_t new_entry, main_q, main_d, skid_q, skid_d;
  logic   main_v_q, main_v_d, skid_v_q, skid_v_d;
  logic   halted_q, halted_d, rdy_q, rdy_d;
  logic   accept, emit;

  decode_fields #(
    .XLEN        (XLEN),
    .IMM_SIGNED  (IMM_SIGNED),
    .TARGET_MODE (TARGET_MODE)
  ) u_fields (
    .instr  (in_instr),
    .pc     (in_pc),
    .fields (new_entry.f),
    .imm    (new_entry.imm),
    .pcb    (new_entry.pcb),
    .pcj    (new_entry.pcj)
  );
  assign new_entry.pc = in_pc;

  // Next-state for main/skid occupancy, halt latch and registered ready.
  always_comb begin
    main_d   = main_q;
    skid_d   = skid_q;
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    halted_d = halted_q;
    accept   = in_valid && rdy_q;
    emit     = main_v_q && out_ready;
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
      halted_d = 1'b0;
    end else begin
      if (emit) begin
        if (skid_v_q) begin
          main_d   = skid_q;
          skid_v_d = 1'b0;
        end else if (accept) begin
          main_d = new_entry;
        end else begin
          main_v_d = 1'b0;
        end
      end else if (accept) begin
        if (main_v_q) begin
          skid_d   = new_entry;
          skid_v_d = 1'b1;
        end else begin
          main_d   = new_entry;
          main_v_d = 1'b1;
        end
      end
      // A newly accepted stop wins over a concurrent resume.
      if (accept && new_entry.f.stop) begin
        halted_d = 1'b1;
      end else if (resume) begin
        halted_d = 1'b0;
      end
    end
    rdy_d = !skid_v_d && !halted_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      halted_q <= 1'b0;
      rdy_q    <= 1'b1;
    end else begin
      main_q   <= main_d;
      skid_q   <= skid_d;
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      halted_q <= halted_d;
      rdy_q    <= rdy_d;
    end
  end

  assign in_ready  = rdy_q;
  assign halted    = halted_q;
  assign out_valid = main_v_q;
  assign out_op    = main_q.f.op;
  assign out_func  = main_q.f.func;
  assign out_rs    = main_q.f.rs;
  assign out_rd    = main_q.f.rd;
  assign out_rt    = main_q.f.rt;
  assign out_sa    = main_q.f.sa;
  assign out_stop  = main_q.f.stop;
  assign out_imm   = main_q.imm;
  assign out_pc    = main_q.pc;
  assign out_pcb   = main_q.pcb;
  assign out_pcj   = main_q.pcj;

endmodule

// File: tb/tb_decode_stage_hs.sv
// Directed bench for decode_stage_hs: PC-relative/signed instance plus an absolute/unsigned one.
module tb_decode_stage_hs;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, flush, resume, out_ready;
  logic [31:0] in_instr, in_pc;

  logic        in_ready, out_valid, out_stop, halted;
  logic [1:0]  out_op;
  logic [4:0]  out_func, out_rs, out_rd, out_rt, out_sa;
  logic [31:0] out_imm, out_pc, out_pcb, out_pcj;

  logic        l_in_ready, l_out_valid, l_out_stop, l_halted;
  logic [1:0]  l_out_op;
  logic [4:0]  l_out_func, l_out_rs, l_out_rd, l_out_rt, l_out_sa;
  logic [31:0] l_out_imm, l_out_pc, l_out_pcb, l_out_pcj;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  decode_stage_hs #(.XLEN(32), .IMM_SIGNED(1), .TARGET_MODE(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .resume(resume),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_func(out_func), .out_rs(out_rs), .out_rd(out_rd), .out_rt(out_rt),
    .out_sa(out_sa), .out_stop(out_stop), .out_imm(out_imm), .out_pc(out_pc),
    .out_pcb(out_pcb), .out_pcj(out_pcj), .halted(halted)
  );

  decode_stage_hs #(.XLEN(32), .IMM_SIGNED(0), .TARGET_MODE(0)) dut_legacy (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(l_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .resume(resume),
    .out_valid(l_out_valid), .out_ready(out_ready), .out_op(l_out_op),
    .out_func(l_out_func), .out_rs(l_out_rs), .out_rd(l_out_rd), .out_rt(l_out_rt),
    .out_sa(l_out_sa), .out_stop(l_out_stop), .out_imm(l_out_imm), .out_pc(l_out_pc),
    .out_pcb(l_out_pcb), .out_pcj(l_out_pcj), .halted(l_halted)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [1:0]  op;
    logic [4:0]  func, rs, rd, rt, sa;
    logic        stop;
    logic [31:0] imm, pcb, pcj;
    logic [31:0] l_imm, l_pcb, l_pcj;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[4];
  logic [31:0] exp_q[$];

  initial begin
    vecs[0] = '{32'h18443200, 32'h00000040, 2'b00, 5'd3, 5'd1, 5'd2, 5'd3, 5'd4, 1'b0,
                32'h00000640, 32'h00000680, 32'h00088680, 32'h00000640, 32'h00000640, 32'h00088640};
    vecs[1] = '{32'h0001FFFC, 32'h00000100, 2'b10, 5'd0, 5'd0, 5'd0, 5'd31, 5'd31, 1'b0,
                32'hFFFFFFFF, 32'h000000FF, 32'h000040FF, 32'h00003FFF, 32'h00003FFF, 32'h00003FFF};
    vecs[2] = '{32'h00000082, 32'hFFFFFFF8, 2'b01, 5'd0, 5'd0, 5'd0, 5'd0, 5'd1, 1'b0,
                32'h00000010, 32'h00000008, 32'h00000008, 32'h00000010, 32'h00000010, 32'h00000010};
    vecs[3] = '{32'h02000006, 32'h00001000, 2'b11, 5'd0, 5'd8, 5'd0, 5'd0, 5'd0, 1'b0,
                32'h00000000, 32'h00001000, 32'hFFC01000, 32'h00000000, 32'h00000000, 32'h00400000};

    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; resume = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_pcj", out_pcj, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Table: one instruction per cycle, each checked one cycle after acceptance.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_instr = vecs[i].instr; in_pc = vecs[i].pc;
      tick();
      in_valid = 1'b0;
      chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("v%0d_op", i), 32'(out_op), 32'(vecs[i].op));
      chk($sformatf("v%0d_func", i), 32'(out_func), 32'(vecs[i].func));
      chk($sformatf("v%0d_rs", i), 32'(out_rs), 32'(vecs[i].rs));
      chk($sformatf("v%0d_rd", i), 32'(out_rd), 32'(vecs[i].rd));
      chk($sformatf("v%0d_rt", i), 32'(out_rt), 32'(vecs[i].rt));
      chk($sformatf("v%0d_sa", i), 32'(out_sa), 32'(vecs[i].sa));
      chk($sformatf("v%0d_stop", i), 32'(out_stop), 32'(vecs[i].stop));
      chk($sformatf("v%0d_pc", i), out_pc, vecs[i].pc);
      chk($sformatf("v%0d_imm", i), out_imm, vecs[i].imm);
      chk($sformatf("v%0d_pcb", i), out_pcb, vecs[i].pcb);
      chk($sformatf("v%0d_pcj", i), out_pcj, vecs[i].pcj);
      chk($sformatf("v%0d_l_imm", i), l_out_imm, vecs[i].l_imm);
      chk($sformatf("v%0d_l_pcb", i), l_out_pcb, vecs[i].l_pcb);
      chk($sformatf("v%0d_l_pcj", i), l_out_pcj, vecs[i].l_pcj);
    end
    tick();
    chk("drain_valid", 32'(out_valid), 32'd0);

    // Back-pressure: 8 entries under random out_ready, scoreboard for order and occupancy.
    begin
      int sent = 0, got = 0, occ = 0;
      logic acc, em;
      for (int cyc = 0; cyc < 300 && got < 8; cyc++) begin
        in_valid  = (sent < 8);
        in_instr  = {5'(sent + 1), 27'h0000100};
        in_pc     = 32'h00002000 + 32'(sent) * 32'd4;
        out_ready = ($urandom_range(0, 1) == 1);
        chk("bp_in_ready", 32'(in_ready), 32'(occ < 2));
        chk("bp_out_valid", 32'(out_valid), 32'(occ > 0));
        acc = in_valid && in_ready;
        em  = out_valid && out_ready;
        if (em) begin
          if (exp_q.size() == 0) begin
            chk("bp_spurious", out_pc, 32'hDEADBEEF);
          end else begin
            chk("bp_order_pc", out_pc, exp_q[0]);
            chk("bp_order_func", 32'(out_func), 32'((exp_q[0] - 32'h00002000) / 4 + 1));
            void'(exp_q.pop_front());
          end
          got++;
        end
        if (acc) begin
          exp_q.push_back(in_pc);
          sent++;
        end
        occ = occ + (acc ? 1 : 0) - (em ? 1 : 0);
        tick();
      end
      in_valid = 1'b0;
      chk("bp_count", 32'(got), 32'd8);
      chk("bp_empty", 32'(out_valid), 32'd0);
    end

    // Halt: stop accepted, intake frozen, stop still drains, resume reopens.
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00000001; in_pc = 32'h00000200;
    tick();
    in_instr = 32'h00000004; in_pc = 32'h00000204;
    chk("halt_set", 32'(halted), 32'd1);
    chk("halt_in_ready", 32'(in_ready), 32'd0);
    chk("halt_stop_held", 32'(out_stop), 32'd1);
    out_ready = 1'b1;
    tick();
    chk("halt_drained", 32'(out_valid), 32'd0);
    tick();
    tick();
    chk("halt_no_accept", 32'(out_valid), 32'd0);
    chk("halt_still", 32'(halted), 32'd1);
    resume = 1'b1;
    tick();
    resume = 1'b0; in_valid = 1'b0;
    chk("resume_halted", 32'(halted), 32'd0);
    chk("resume_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("resume_no_entry", 32'(out_valid), 32'd0);

    // Flush with main and skid full plus a concurrent offer.
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00000000; in_pc = 32'h00000300;
    tick();
    in_pc = 32'h00000304;
    tick();
    chk("fl_full", 32'(in_ready), 32'd0);
    in_pc = 32'h00000308; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("fl_out_valid", 32'(out_valid), 32'd0);
    chk("fl_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("fl_nothing_after", 32'(out_valid), 32'd0);

    // Flush into an empty stage discards the same-cycle accept.
    in_valid = 1'b1; in_pc = 32'h0000030C; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_accept_dropped", 32'(out_valid), 32'd0);

    // Asynchronous reset mid-stream.
    in_valid = 1'b1; in_instr = 32'h18443200; in_pc = 32'h00000440;
    tick();
    in_valid = 1'b0;
    chk("ar_loaded", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar_out_valid", 32'(out_valid), 32'd0);
    chk("ar_out_pc", out_pc, 32'd0);
    chk("ar_out_func", 32'(out_func), 32'd0);
    chk("ar_in_ready", 32'(in_ready), 32'd1);
    tick();
    rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
